// File: rtl/fir_tm_pkg.sv
// ---------------------------------------------------------------------------
// fir_tm_pkg
//
// Definitions shared by the time-multiplexed FIR tap sequencer:
//   - state_e     : sequencer state encoding (IDLE, MAC, OUT)
//   - DL_DEPTH    : depth of the SRL delay line (maximum tap count)
//   - ADDR_W      : width of the delay-line / coefficient address
//   - acc_width() : accumulator width derived from sample and coefficient
//                   widths, sized for 16 full-scale products
//   - frac_shift(): right shift that turns a Q1.(CWL-1) product sum back
//                   into a sample-scale value
//   - sat_max() / sat_min(): signed limits of a WL-bit output word
// ---------------------------------------------------------------------------
package fir_tm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   localparam int DL_DEPTH = 16;
   localparam int ADDR_W   = 4;

   localparam int WL_DEFAULT  = 12;
   localparam int CWL_DEFAULT = 12;

   // Four guard bits cover the sum of DL_DEPTH (= 2^4) full-scale products.
   function automatic int acc_width(input int wl, input int cwl);
      return wl + cwl + 4;
   endfunction

   // Coefficients are Q1.(CWL-1); dropping CWL-1 LSBs restores sample scale.
   function automatic int frac_shift(input int cwl);
      return cwl - 1;
   endfunction

   function automatic int sat_max(input int wl);
      return (1 << (wl - 1)) - 1;
   endfunction

   function automatic int sat_min(input int wl);
      return -(1 << (wl - 1));
   endfunction

endpackage

// File: rtl/fir_tm_tap_sequencer_if.sv
// ---------------------------------------------------------------------------
// fir_tm_tap_sequencer_if
//
// Bundles every non-clock signal of the tap sequencer:
//   sample in    : in_valid, in_ready, in_data
//   result out   : out_valid, out_ready, out_data
//   delay line   : dl_en, dl_in, dl_addr, dl_out
//   coefficients : coef_addr, coef_data
//
// Handshake rules (both in_* and out_* channels): a transfer happens on a
// rising CLK edge where valid and ready are both 1. A source holding valid
// keeps its data stable until that edge; ready may be driven independently
// of valid; neither side may withdraw valid once it is raised without a
// transfer. dl_out and coef_data are combinational responses to the
// addresses presented in the same cycle.
//
// modport master : the sequencer engine
// modport slave  : the surrounding datapath (source, sink, SRL, coef store)
// ---------------------------------------------------------------------------
interface fir_tm_tap_sequencer_if
   import fir_tm_pkg::*;
#(
   parameter int WL  = WL_DEFAULT,
   parameter int CWL = CWL_DEFAULT
);

   logic              in_valid;
   logic              in_ready;
   logic [WL-1:0]     in_data;

   logic              out_valid;
   logic              out_ready;
   logic [WL-1:0]     out_data;

   logic              dl_en;
   logic [WL-1:0]     dl_in;
   logic [ADDR_W-1:0] dl_addr;
   logic [WL-1:0]     dl_out;

   logic [ADDR_W-1:0] coef_addr;
   logic [CWL-1:0]    coef_data;

   modport master (
      input  in_valid, in_data, out_ready, dl_out, coef_data,
      output in_ready, out_valid, out_data, dl_en, dl_in, dl_addr, coef_addr
   );

   modport slave (
      output in_valid, in_data, out_ready, dl_out, coef_data,
      input  in_ready, out_valid, out_data, dl_en, dl_in, dl_addr, coef_addr
   );

endinterface

// File: rtl/fir_tm_sat.sv
// ---------------------------------------------------------------------------
// fir_tm_sat
//
// Combinational output stage: arithmetic right shift of the accumulator by
// CWL-1 (floor toward minus infinity), then clamp to the signed WL-bit range.
//
// Ports:
//   acc_i : signed accumulator value, ACCW bits
//   sat_o : shifted and saturated result, WL bits (two's complement)
// ---------------------------------------------------------------------------
module fir_tm_sat
   import fir_tm_pkg::*;
#(
   parameter int WL   = WL_DEFAULT,
   parameter int CWL  = CWL_DEFAULT,
   parameter int ACCW = acc_width(WL, CWL)
) (
   input  logic signed [ACCW-1:0] acc_i,
   output logic        [WL-1:0]   sat_o
);

   localparam int SHIFT = frac_shift(CWL);
   localparam logic signed [ACCW-1:0] MAX_V = ACCW'(sat_max(WL));
   localparam logic signed [ACCW-1:0] MIN_V = ACCW'(sat_min(WL));

   logic signed [ACCW-1:0] shifted;

   always_comb begin
      shifted = acc_i >>> SHIFT;
      if (shifted > MAX_V) begin
         sat_o = MAX_V[WL-1:0];
      end else if (shifted < MIN_V) begin
         sat_o = MIN_V[WL-1:0];
      end else begin
         sat_o = shifted[WL-1:0];
      end
   end

endmodule

// File: rtl/fir_tm_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tm_tap_sequencer
//
// Control and MAC engine of a time-multiplexed FIR built around a 16-deep
// SRL delay line. For each accepted input sample the engine:
//   1. shifts the sample into the delay line (dl_en pulse in IDLE),
//   2. sweeps dl_addr/coef_addr over taps 0..TAPS-1, accumulating
//      x[n-k] * c[k] at full precision (one tap per cycle),
//   3. presents the shifted, saturated sum on out_data until taken.
// One sample costs TAPS+2 cycles: 1 IDLE + TAPS MAC + 1 OUT.
//
// Parameters:
//   WL   : sample / output word length (signed)
//   CWL  : coefficient word length (signed Q1.(CWL-1))
//   TAPS : number of taps, 1..16
//   ACCW : accumulator width
//
// Ports:
//   CLK       : clock, rising edge
//   RSTn      : asynchronous active-low reset
//   bus       : sample, result, delay-line and coefficient signals
//   dbg_state : current sequencer state
// ---------------------------------------------------------------------------
module fir_tm_tap_sequencer
   import fir_tm_pkg::*;
#(
   parameter int WL   = WL_DEFAULT,
   parameter int CWL  = CWL_DEFAULT,
   parameter int TAPS = DL_DEPTH,
   parameter int ACCW = acc_width(WL, CWL)
) (
   input  logic                   CLK,
   input  logic                   RSTn,
   fir_tm_tap_sequencer_if.master bus,
   output state_e                 dbg_state
);

   localparam int PRODW = WL + CWL;
   localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(TAPS - 1);

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       k_q, k_d;
   logic signed [ACCW-1:0]  acc_q, acc_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic [WL-1:0]           out_data_q, out_data_d;

   logic signed [PRODW-1:0] smp_ext;
   logic signed [PRODW-1:0] coef_ext;
   logic signed [PRODW-1:0] prod;
   logic signed [ACCW-1:0]  prod_ext;
   logic signed [ACCW-1:0]  acc_sum;
   logic [WL-1:0]           sat_y;

   // Both operands are sign-extended to the product width so the multiply
   // is exact; the WL+CWL-bit result cannot overflow.
   always_comb begin
      smp_ext  = {{CWL{bus.dl_out[WL-1]}}, bus.dl_out};
      coef_ext = {{WL{bus.coef_data[CWL-1]}}, bus.coef_data};
      prod     = smp_ext * coef_ext;
      prod_ext = {{(ACCW-PRODW){prod[PRODW-1]}}, prod};
      acc_sum  = acc_q + prod_ext;
   end

   // acc_sum already includes the last tap on the final MAC cycle, so the
   // result can be registered on the edge that enters OUT.
   fir_tm_sat #(
      .WL   (WL),
      .CWL  (CWL),
      .ACCW (ACCW)
   ) u_sat (
      .acc_i (acc_sum),
      .sat_o (sat_y)
   );

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      acc_d       = acc_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      case (state_q)
         ST_IDLE: begin
            // in_ready is low for the first cycle after reset and rises here.
            in_ready_d = 1'b1;
            if (bus.in_valid && in_ready_q) begin
               state_d    = ST_MAC;
               k_d        = '0;
               acc_d      = '0;
               in_ready_d = 1'b0;
            end
         end

         ST_MAC: begin
            acc_d = acc_sum;
            if (k_q == LAST_K) begin
               state_d     = ST_OUT;
               k_d         = '0;
               out_valid_d = 1'b1;
               out_data_d  = sat_y;
            end else begin
               k_d = k_q + ADDR_W'(1);
            end
         end

         ST_OUT: begin
            if (bus.out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            k_d         = '0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // k is forced back to 0 whenever MAC ends, so it doubles as the read
   // address and reads tap 0 outside MAC.
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.dl_en     = bus.in_valid & in_ready_q;
   assign bus.dl_in     = bus.in_data;
   assign bus.dl_addr   = k_q;
   assign bus.coef_addr = k_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_fir_tm_tap_sequencer.sv
module tb_fir_tm_tap_sequencer;
   import fir_tm_pkg::*;

   localparam int WL  = 12;
   localparam int CWL = 12;
   localparam longint YMAX = (longint'(1) << (WL - 1)) - 1;
   localparam longint YMIN = -(longint'(1) << (WL - 1));

   // ---------------- clock / reset ----------------
   logic CLK  = 1'b0;
   logic RSTn = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- DUTs ----------------
   fir_tm_tap_sequencer_if #(.WL(WL), .CWL(CWL)) bus4 ();
   fir_tm_tap_sequencer_if #(.WL(WL), .CWL(CWL)) bus16 ();
   state_e dbg4, dbg16;

   fir_tm_tap_sequencer #(.WL(WL), .CWL(CWL), .TAPS(4)) u_dut4 (
      .CLK(CLK), .RSTn(RSTn), .bus(bus4), .dbg_state(dbg4)
   );
   fir_tm_tap_sequencer #(.WL(WL), .CWL(CWL), .TAPS(16)) u_dut16 (
      .CLK(CLK), .RSTn(RSTn), .bus(bus16), .dbg_state(dbg16)
   );

   // ---------------- delay lines and coefficient stores ----------------
   logic [WL-1:0]  dl4 [16];
   logic [WL-1:0]  dl16 [16];
   logic [CWL-1:0] coef4 [16];
   logic [CWL-1:0] coef16 [16];
   int dlen4_cnt  = 0;
   int dlen16_cnt = 0;

   always @(posedge CLK) begin
      if (bus4.dl_en) begin
         for (int i = 15; i > 0; i--) dl4[i] <= dl4[i-1];
         dl4[0] <= bus4.dl_in;
         dlen4_cnt <= dlen4_cnt + 1;
      end
      if (bus16.dl_en) begin
         for (int i = 15; i > 0; i--) dl16[i] <= dl16[i-1];
         dl16[0] <= bus16.dl_in;
         dlen16_cnt <= dlen16_cnt + 1;
      end
   end

   assign bus4.dl_out     = dl4[bus4.dl_addr];
   assign bus4.coef_data  = coef4[bus4.coef_addr];
   assign bus16.dl_out    = dl16[bus16.dl_addr];
   assign bus16.coef_data = coef16[bus16.coef_addr];

   // ---------------- scoreboard state ----------------
   logic [WL-1:0] exp_q[$];
   logic [WL-1:0] h4 [16];
   logic [WL-1:0] h16 [16];
   int checks = 0;
   int errors = 0;

   function automatic logic [WL-1:0] model_y(input logic [WL-1:0] h [16],
                                             input logic [CWL-1:0] c [16],
                                             input int taps);
      longint acc = 0;
      longint q;
      for (int k = 0; k < taps; k++)
         acc += longint'($signed(h[k])) * longint'($signed(c[k]));
      q = acc >>> (CWL - 1);
      if (q > YMAX) q = YMAX;
      else if (q < YMIN) q = YMIN;
      return q[WL-1:0];
   endfunction

   // ---------------- accessors (s=1 selects the 16-tap DUT) ----------------
   function automatic logic f_ov(input bit s);
      return s ? bus16.out_valid : bus4.out_valid;
   endfunction
   function automatic logic [WL-1:0] f_od(input bit s);
      return s ? bus16.out_data : bus4.out_data;
   endfunction
   function automatic logic f_ir(input bit s);
      return s ? bus16.in_ready : bus4.in_ready;
   endfunction
   function automatic logic f_den(input bit s);
      return s ? bus16.dl_en : bus4.dl_en;
   endfunction
   function automatic logic [3:0] f_addr(input bit s);
      return s ? bus16.dl_addr : bus4.dl_addr;
   endfunction
   function automatic state_e f_dbg(input bit s);
      return s ? dbg16 : dbg4;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_in(input bit s, input logic v, input logic [WL-1:0] d);
      if (s) begin bus16.in_valid = v; bus16.in_data = d; end
      else begin bus4.in_valid = v; bus4.in_data = d; end
   endtask

   task automatic drive_or(input bit s, input logic r);
      if (s) bus16.out_ready = r;
      else bus4.out_ready = r;
   endtask

   task automatic shift_hist(input bit s, input logic [WL-1:0] d);
      if (s) begin
         for (int i = 15; i > 0; i--) h16[i] = h16[i-1];
         h16[0] = d;
         exp_q.push_back(model_y(h16, coef16, 16));
      end else begin
         for (int i = 15; i > 0; i--) h4[i] = h4[i-1];
         h4[0] = d;
         exp_q.push_back(model_y(h4, coef4, 4));
      end
   endtask

   task automatic send(input bit s, input logic [WL-1:0] d, output bit ok);
      int n = 0;
      drive_in(s, 1'b1, d);
      while (!f_ir(s) && n < 100) begin tick(); n++; end
      ok = f_ir(s);
      tick();
      drive_in(s, 1'b0, '0);
      if (ok) shift_hist(s, d);
   endtask

   task automatic recv(input bit s, output logic [WL-1:0] d, output bit ok);
      int n = 0;
      drive_or(s, 1'b1);
      while (!f_ov(s) && n < 100) begin tick(); n++; end
      ok = f_ov(s);
      d  = f_od(s);
      tick();
      drive_or(s, 1'b0);
   endtask

   task automatic flush_line(input bit s, input int taps);
      logic [WL-1:0] d;
      bit ok;
      for (int i = 0; i < taps; i++) begin
         send(s, '0, ok);
         recv(s, d, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL flush_timeout: dut=%0d out_valid never rose", s); end
      end
      exp_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drive_in(0, 1'b1, 12'd5);
      drive_in(1, 1'b1, 12'd5);
      tick(); tick();
      for (int s = 0; s < 2; s++) begin
         checks++; if (f_ov(s == 1) !== 1'b0) begin errors++; $display("FAIL reset_out_valid: dut=%0d got %0b expected 0", s, f_ov(s == 1)); end
         checks++; if (f_od(s == 1) !== '0) begin errors++; $display("FAIL reset_out_data: dut=%0d got %0d expected 0", s, f_od(s == 1)); end
         checks++; if (f_ir(s == 1) !== 1'b0) begin errors++; $display("FAIL reset_in_ready: dut=%0d got %0b expected 0", s, f_ir(s == 1)); end
         checks++; if (f_den(s == 1) !== 1'b0) begin errors++; $display("FAIL reset_dl_en: dut=%0d got %0b expected 0", s, f_den(s == 1)); end
         checks++; if (f_addr(s == 1) !== 4'd0) begin errors++; $display("FAIL reset_dl_addr: dut=%0d got %0d expected 0", s, f_addr(s == 1)); end
         checks++; if (f_dbg(s == 1) !== ST_IDLE) begin errors++; $display("FAIL reset_state: dut=%0d got %0d expected %0d", s, f_dbg(s == 1), ST_IDLE); end
      end
      drive_in(0, 1'b0, '0);
      drive_in(1, 1'b0, '0);
      RSTn = 1'b1;
      tick();
      for (int s = 0; s < 2; s++) begin
         checks++; if (f_ir(s == 1) !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: dut=%0d got %0b expected 1", s, f_ir(s == 1)); end
      end
   endtask

   task automatic test_single_tap();
      int n = 0;
      int d0;
      logic [WL-1:0] d, e;
      bit ok;
      coef4[0] = 12'h7FF;
      for (int k = 1; k < 16; k++) coef4[k] = '0;
      d0 = dlen4_cnt;
      send(0, 12'd100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_accept: in_ready never rose"); end
      // The accept edge is behind us; tap k is addressed in the k-th MAC cycle.
      while (!f_ov(0) && n < 20) begin
         checks++;
         if (f_addr(0) !== 4'(n)) begin errors++; $display("FAIL single_dl_addr: cycle %0d got %0d expected %0d", n, f_addr(0), n); end
         tick();
         n++;
      end
      checks++; if (n != 4) begin errors++; $display("FAIL single_latency: out_valid after %0d cycles expected 4", n); end
      checks++; if (f_addr(0) !== 4'd0) begin errors++; $display("FAIL single_addr_out: got %0d expected 0", f_addr(0)); end
      recv(0, d, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || d !== e) begin errors++; $display("FAIL single_data: got %0d expected %0d", $signed(d), $signed(e)); end
      checks++; if (d !== 12'd99) begin errors++; $display("FAIL single_value: got %0d expected 99", $signed(d)); end
      checks++; if (dlen4_cnt - d0 != 1) begin errors++; $display("FAIL single_dl_en_pulses: got %0d expected 1", dlen4_cnt - d0); end
   endtask

   task automatic test_impulse();
      logic [WL-1:0] want [4];
      logic [WL-1:0] d, e;
      bit ok;
      want[0] = 12'd128; want[1] = 12'd256; want[2] = 12'd384; want[3] = 12'd512;
      coef4[0] = 12'h100; coef4[1] = 12'h200; coef4[2] = 12'h300; coef4[3] = 12'h400;
      flush_line(0, 4);
      for (int i = 0; i < 4; i++) begin
         send(0, (i == 0) ? 12'd1024 : 12'd0, ok);
         recv(0, d, ok);
         e = exp_q.pop_front();
         checks++; if (!ok || d !== e) begin errors++; $display("FAIL impulse_model[%0d]: got %0d expected %0d", i, $signed(d), $signed(e)); end
         checks++; if (d !== want[i]) begin errors++; $display("FAIL impulse_value[%0d]: got %0d expected %0d", i, $signed(d), want[i]); end
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      int d0;
      logic [WL-1:0] d, e;
      bit ok;
      d0 = dlen4_cnt;
      send(0, 12'd300, ok);
      while (!f_ov(0) && n < 50) begin tick(); n++; end
      checks++; if (!f_ov(0)) begin errors++; $display("FAIL bp_timeout: out_valid never rose"); end
      e = exp_q[0];
      for (int c = 0; c < 10; c++) begin
         drive_in(0, 1'b1, 12'($urandom_range(0, 4095)));
         #1;
         checks++; if (f_ov(0) !== 1'b1) begin errors++; $display("FAIL bp_out_valid: cycle %0d got %0b expected 1", c, f_ov(0)); end
         checks++; if (f_od(0) !== e) begin errors++; $display("FAIL bp_out_data: cycle %0d got %0d expected %0d", c, $signed(f_od(0)), $signed(e)); end
         checks++; if (f_ir(0) !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %0b expected 0", c, f_ir(0)); end
         checks++; if (f_den(0) !== 1'b0) begin errors++; $display("FAIL bp_dl_en: cycle %0d got %0b expected 0", c, f_den(0)); end
         tick();
      end
      drive_in(0, 1'b0, '0);
      recv(0, d, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || d !== e) begin errors++; $display("FAIL bp_data: got %0d expected %0d", $signed(d), $signed(e)); end
      checks++; if (f_ov(0) !== 1'b0) begin errors++; $display("FAIL bp_release: out_valid got %0b expected 0", f_ov(0)); end
      checks++; if (dlen4_cnt - d0 != 1) begin errors++; $display("FAIL bp_dl_en_pulses: got %0d expected 1", dlen4_cnt - d0); end
   endtask

   task automatic test_saturation();
      logic [WL-1:0] d, e;
      bit ok;
      for (int k = 0; k < 16; k++) coef16[k] = 12'h7FF;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 16; i++) begin
            send(1, (pass == 0) ? 12'h7FF : 12'h800, ok);
            recv(1, d, ok);
            e = exp_q.pop_front();
            checks++; if (!ok || d !== e) begin errors++; $display("FAIL sat_model[%0d][%0d]: got %0d expected %0d", pass, i, $signed(d), $signed(e)); end
         end
         checks++;
         if (d !== ((pass == 0) ? 12'h7FF : 12'h800))
            begin errors++; $display("FAIL sat_limit[%0d]: got 0x%03h expected 0x%03h", pass, d, (pass == 0) ? 12'h7FF : 12'h800); end
      end
   endtask

   task automatic test_reset_mid_mac();
      logic [WL-1:0] d, e;
      bit ok;
      for (int k = 0; k < 16; k++) coef16[k] = 12'($urandom_range(0, 4095));
      send(1, 12'($urandom_range(0, 4095)), ok);
      tick(); tick();
      checks++; if (dbg16 !== ST_MAC || f_addr(1) !== 4'd2) begin errors++; $display("FAIL abort_setup: state %0d addr %0d expected %0d addr 2", dbg16, f_addr(1), ST_MAC); end
      drive_in(1, 1'b1, 12'd77);
      RSTn = 1'b0;
      #1;
      checks++; if (f_ov(1) !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %0b expected 0", f_ov(1)); end
      checks++; if (f_ir(1) !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %0b expected 0", f_ir(1)); end
      checks++; if (f_den(1) !== 1'b0) begin errors++; $display("FAIL abort_dl_en: got %0b expected 0", f_den(1)); end
      checks++; if (f_addr(1) !== 4'd0 || dbg16 !== ST_IDLE) begin errors++; $display("FAIL abort_state: addr %0d state %0d expected addr 0 state %0d", f_addr(1), dbg16, ST_IDLE); end
      tick();
      drive_in(1, 1'b0, '0);
      RSTn = 1'b1;
      exp_q.delete();
      tick();
      checks++; if (f_ir(1) !== 1'b1 || f_ov(1) !== 1'b0) begin errors++; $display("FAIL abort_recover: in_ready %0b out_valid %0b expected 1 0", f_ir(1), f_ov(1)); end
      send(1, 12'($urandom_range(0, 4095)), ok);
      recv(1, d, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || d !== e) begin errors++; $display("FAIL abort_next_data: got %0d expected %0d", $signed(d), $signed(e)); end
   endtask

   task automatic test_back_to_back();
      int acc_cyc[$];
      int outs = 0;
      int d0;
      bit take;
      bit ok;
      logic [WL-1:0] cur, d, e;
      d0 = dlen16_cnt;
      exp_q.delete();
      cur = 12'($urandom_range(0, 4095));
      drive_or(1, 1'b1);
      drive_in(1, 1'b1, cur);
      for (int cyc = 0; cyc < 100; cyc++) begin
         take = f_ir(1);
         if (f_ov(1)) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_extra_output: got %0d with nothing pending", $signed(f_od(1)));
            end else begin
               e = exp_q.pop_front();
               outs++;
               if (f_od(1) !== e) begin errors++; $display("FAIL b2b_data: got %0d expected %0d", $signed(f_od(1)), $signed(e)); end
            end
         end
         if (take) begin
            shift_hist(1, cur);
            acc_cyc.push_back(cyc);
         end
         tick();
         if (take) begin
            cur = 12'($urandom_range(0, 4095));
            drive_in(1, 1'b1, cur);
         end
      end
      drive_in(1, 1'b0, '0);
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
         recv(1, d, ok);
         e = exp_q.pop_front();
         outs++;
         checks++; if (!ok || d !== e) begin errors++; $display("FAIL b2b_drain: got %0d expected %0d", $signed(d), $signed(e)); end
      end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         checks++;
         if (acc_cyc[i] - acc_cyc[i-1] != 18) begin errors++; $display("FAIL b2b_period: got %0d cycles expected 18", acc_cyc[i] - acc_cyc[i-1]); end
      end
      checks++; if (acc_cyc.size() < 5) begin errors++; $display("FAIL b2b_accepts: got %0d expected at least 5", acc_cyc.size()); end
      checks++; if (dlen16_cnt - d0 != acc_cyc.size()) begin errors++; $display("FAIL b2b_dl_en_pulses: got %0d expected %0d", dlen16_cnt - d0, acc_cyc.size()); end
      checks++; if (outs != acc_cyc.size()) begin errors++; $display("FAIL b2b_output_count: got %0d expected %0d", outs, acc_cyc.size()); end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int k = 0; k < 16; k++) begin
         coef4[k] = '0; coef16[k] = '0; h4[k] = '0; h16[k] = '0;
      end
      drive_in(0, 1'b0, '0);
      drive_in(1, 1'b0, '0);
      drive_or(0, 1'b0);
      drive_or(1, 1'b0);

      test_reset();
      flush_line(0, 4);
      flush_line(1, 16);
      test_single_tap();
      test_impulse();
      test_backpressure();
      test_saturation();
      test_reset_mid_mac();
      test_back_to_back();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached after %0d checks", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
